// File: rtl/serial_xnor_compare_if.sv
// Request/result bundle between a requesting unit and the bit-serial equality checker.
// The master drives the request side; the slave returns the handshake and the result.
interface serial_xnor_compare_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [IW-1:0]    mism_idx;

    modport master (
        output start, a, b,
        input  busy, done, equal, mism_idx
    );

    modport slave (
        input  start, a, b,
        output busy, done, equal, mism_idx
    );
endinterface

// File: rtl/serial_xnor_compare.sv
// Compares two WIDTH-bit operands LSB-first through a single XNOR bit cell,
// stopping at the first differing bit and reporting equal / lowest mismatch index.
module serial_xnor_compare #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_xnor_compare_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [IW-1:0]    count_reg, count_next;
    logic [IW-1:0]    mism_idx_reg, mism_idx_next;
    logic             equal_reg, equal_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] sa_shift;
    logic [WIDTH-1:0] sb_shift;
    logic             bit_eq;

    // The single shared equality cell: only bit 0 of each shift register is ever compared.
    assign bit_eq = ~(sa_reg[0] ^ sb_reg[0]);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign sa_shift[gi] = 1'b0;
                assign sb_shift[gi] = 1'b0;
            end else begin : g_body
                assign sa_shift[gi] = sa_reg[gi+1];
                assign sb_shift[gi] = sb_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        sa_next       = sa_reg;
        sb_next       = sb_reg;
        count_next    = count_reg;
        mism_idx_next = mism_idx_reg;
        equal_next    = equal_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    sa_next       = bus.a;
                    sb_next       = bus.b;
                    count_next    = '0;
                    equal_next    = 1'b0;
                    mism_idx_next = '0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                if (!bit_eq) begin
                    equal_next    = 1'b0;
                    mism_idx_next = count_reg;
                    state_next    = DONE;
                end else if (count_reg == LAST_IDX) begin
                    // Terminal check comes before the increment, so count never wraps.
                    equal_next    = 1'b1;
                    mism_idx_next = '0;
                    state_next    = DONE;
                end else begin
                    sa_next    = sa_shift;
                    sb_next    = sb_shift;
                    count_next = count_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Handshake flags are registered from the next state so they line up with it.
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            sa_reg       <= '0;
            sb_reg       <= '0;
            count_reg    <= '0;
            mism_idx_reg <= '0;
            equal_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sa_reg       <= sa_next;
            sb_reg       <= sb_next;
            count_reg    <= count_next;
            mism_idx_reg <= mism_idx_next;
            equal_reg    <= equal_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.equal    = equal_reg;
    assign bus.mism_idx = mism_idx_reg;
endmodule

// File: tb/tb_serial_xnor_compare.sv
// Randomized self-checking bench for serial_xnor_compare; expected results come from
// a word-level model (XOR of the operands, lowest set bit gives index and latency).
module tb_serial_xnor_compare;
    localparam int W  = 8;
    localparam int IW = $clog2(W);

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    serial_xnor_compare_if #(.WIDTH(W)) bus ();

    serial_xnor_compare #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level reference: first differing bit from the LSB decides result and latency.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic eq, output int idx, output int lat);
        logic [W-1:0] d;
        d   = x ^ y;
        eq  = 1'b1;
        idx = 0;
        lat = W;
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) begin
                eq  = 1'b0;
                idx = i;
                lat = i + 1;
            end
        end
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.equal, bus.mism_idx} !== {3'b000, {IW{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_state: busy=%0b done=%0b equal=%0b idx=%0d, required all 0",
                     bus.busy, bus.done, bus.equal, bus.mism_idx);
        end
        reset = 1'b0;
        $display("test_reset: outputs checked while reset held");
    endtask

    // One operation; mode 0 = quiet inputs while busy, 1 = random start/operand noise,
    // 2 = start held high with a=b=all-ones while busy (must be ignored).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int mode, input string name);
        logic          exp_eq;
        int            idx;
        int            lat;
        logic [IW-1:0] exp_idx;
        model(ta, tb_v, exp_eq, idx, lat);
        exp_idx   = IW'(idx);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(posedge clk);
        #1;
        for (int k = 0; k <= lat + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (bus.busy !== (k <= lat)) begin
                n_err++;
                $display("FAIL %s busy@E%0d: got %0b, required %0b", name, k, bus.busy, (k <= lat));
            end
            n_cmp++;
            if (bus.done !== (k == lat)) begin
                n_err++;
                $display("FAIL %s done@E%0d: got %0b, required %0b", name, k, bus.done, (k == lat));
            end
            n_cmp++;
            if (k >= lat) begin
                if (bus.equal !== exp_eq || bus.mism_idx !== exp_idx) begin
                    n_err++;
                    $display("FAIL %s result@E%0d: equal=%0b idx=%0d, required equal=%0b idx=%0d",
                             name, k, bus.equal, bus.mism_idx, exp_eq, exp_idx);
                end
            end else if (bus.equal !== 1'b0 || bus.mism_idx !== '0) begin
                n_err++;
                $display("FAIL %s cleared@E%0d: equal=%0b idx=%0d, required equal=0 idx=0",
                         name, k, bus.equal, bus.mism_idx);
            end
            if (k < lat && mode == 1) begin
                bus.start = 1'($urandom);
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
            end else if (k < lat && mode == 2) begin
                bus.start = 1'b1;
                bus.a     = '1;
                bus.b     = '1;
            end else begin
                bus.start = 1'b0;
            end
        end
        $display("%s: a=%h b=%h -> equal=%0b idx=%0d latency=%0d", name, ta, tb_v, exp_eq, exp_idx, lat);
    endtask

    task automatic test_directed();
        run_op(8'hA5, 8'hA5, 0, "equal_a5");
        run_op(8'hA5, 8'hA4, 0, "mism_bit0");
        run_op(8'h80, 8'h00, 0, "mism_bit7");
        run_op(8'h0F, 8'h0B, 2, "ignore_restart");
    endtask

    task automatic test_idle_hold();
        run_op(8'h3C, 8'h1C, 0, "hold_setup");
        for (int k = 0; k < 4; k++) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.equal !== 1'b0 || bus.mism_idx !== IW'(5)) begin
                n_err++;
                $display("FAIL idle_hold cycle %0d: busy=%0b done=%0b equal=%0b idx=%0d, required 0/0/0/5",
                         k, bus.busy, bus.done, bus.equal, bus.mism_idx);
            end
        end
        $display("test_idle_hold: result held over 4 idle cycles");
    endtask

    task automatic test_reset_midop();
        bus.start = 1'b1;
        bus.a     = 8'hA5;
        bus.b     = 8'hA5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.equal, bus.mism_idx} !== {3'b000, {IW{1'b0}}}) begin
            n_err++;
            $display("FAIL async_reset: busy=%0b done=%0b equal=%0b idx=%0d, required all 0",
                     bus.busy, bus.done, bus.equal, bus.mism_idx);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL aborted_op cycle %0d: busy=%0b done=%0b, required 0/0", k, bus.busy, bus.done);
            end
        end
        $display("test_reset_midop: reset between E3 and E4, no done pulse");
        run_op(8'h00, 8'h00, 0, "post_reset_zero");
    endtask

    task automatic test_back_to_back(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                     input int nops, input string name);
        logic          exp_eq;
        int            idx;
        int            lat;
        int            per;
        int            ph;
        logic [IW-1:0] exp_idx;
        model(ta, tb_v, exp_eq, idx, lat);
        exp_idx   = IW'(idx);
        per       = lat + 2;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(posedge clk);
        #1;
        for (int j = 0; j < nops * per; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            ph = j % per;
            n_cmp++;
            if (bus.busy !== (ph <= lat) || bus.done !== (ph == lat)) begin
                n_err++;
                $display("FAIL %s cycle %0d: busy=%0b done=%0b, required busy=%0b done=%0b",
                         name, j, bus.busy, bus.done, (ph <= lat), (ph == lat));
            end
            if (ph == lat) begin
                n_cmp++;
                if (bus.equal !== exp_eq || bus.mism_idx !== exp_idx) begin
                    n_err++;
                    $display("FAIL %s result cycle %0d: equal=%0b idx=%0d, required equal=%0b idx=%0d",
                             name, j, bus.equal, bus.mism_idx, exp_eq, exp_idx);
                end
            end
        end
        bus.start = 1'b0;
        $display("%s: a=%h b=%h, %0d ops every %0d cycles", name, ta, tb_v, nops, per);
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           kind;
        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 2));
            x    = W'($urandom);
            if (kind == 0)      y = x;
            else if (kind == 1) y = x ^ (W'(1) << $urandom_range(0, W - 1));
            else                y = W'($urandom);
            run_op(x, y, int'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_directed();
        test_idle_hold();
        test_reset_midop();
        test_back_to_back(8'h01, 8'h00, 4, "b2b_bit0");
        test_back_to_back(8'h5A, 8'h5A, 2, "b2b_equal");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_xnor_compare.md
# serial_xnor_compare

Sequential controller that checks two WIDTH-bit operands for equality one bit per cycle, using a single 1-bit XNOR cell as its only comparison datapath. It accepts a start request, shifts both operands LSB-first through the XNOR, and stops early on the first differing bit. It then reports equal/not-equal and the index of the lowest mismatching bit through a start/busy/done handshake. It sits between a requesting unit and the shared 1-bit equality cell and sequences that cell over multi-bit words.

## Interface

- WIDTH, 8, operand width in bits; legal range 2..64.
- IW, $clog2(WIDTH), width of the index/counter field; derived, not overridden.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result valid.
- equal  output  1  1 = all bits matched; held until next accept.
- mism_idx  output  IW  lowest mismatching bit index; 0 when equal; held until next accept.

## Operation

- The block uses one clock. Reset is asynchronous and active-high.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE with start=1 at an edge: capture a and b into shift registers sa and sb, set count=0, clear equal and mism_idx, go to SHIFT.
- IDLE with start=0: remain in IDLE; all registers hold.
- SHIFT, each edge: eq = ~(sa[0] ^ sb[0]).
  - If eq=0: equal<=0, mism_idx<=count, go to DONE (early out).
  - Else if count==WIDTH-1: equal<=1, mism_idx<=0, go to DONE.
  - Else: shift sa and sb right by 1, count<=count+1, stay in SHIFT.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queuing. Operands changing while busy have no effect.
- Counter never wraps: the terminal check at WIDTH-1 precedes the increment.
- Reset, asserted at any time including mid-operation: immediately go to IDLE with busy=0, done=0, equal=0, mism_idx=0, sa=sb=0, count=0. No done pulse is produced for an aborted operation.

## Timing

- Edge E0 is the edge at which start is accepted in IDLE. busy rises after E0.
- Bit i is compared at edge E(i+1).
- Mismatch at bit i: done is high from E(i+1) to E(i+2). Latency to done is i+1 cycles.
- Full match: done is high from E(WIDTH) to E(WIDTH+1). Latency is WIDTH cycles.
- equal and mism_idx are valid in the done cycle and stable until the next accepting edge.
- busy falls at the edge that leaves DONE, the same edge at which done falls.
- Earliest next accept is the edge after DONE exits. With start held high, operations repeat back-to-back every (latency+2) cycles.
- Outputs are registered. There is no combinational path from start, a, or b to any output.

## Test plan

- WIDTH=8, a=8'hA5, b=8'hA5, start pulse at E0 -> busy high E0..E9; done only in the E8–E9 cycle; equal=1, mism_idx=0.
- a=8'hA5, b=8'hA4 -> mismatch at bit 0; done in the E1–E2 cycle; equal=0, mism_idx=0; busy low after E2.
- a=8'h80, b=8'h00 -> done in the E8–E9 cycle; equal=0, mism_idx=7. This covers the last-bit mismatch with no counter wrap.
- a=8'h0F, b=8'h0B, then start re-pulsed at E2 with a=b=8'hFF -> second request ignored; result equal=0, mism_idx=2; done in the E3–E4 cycle.
- Reset asserted asynchronously between E3 and E4 of an 8-bit equal compare -> busy, done, equal, and mism_idx go to 0 immediately with no done pulse. A new start with a=b=8'h00 after release gives equal=1 after 8 cycles.
- start held high continuously with a=8'h01, b=8'h00 -> a done pulse every 3 cycles, each with equal=0, mism_idx=0, and busy high throughout each operation.
